// File: rtl/four_bank_mem_if.sv
// ---------------------------------------------------------------------------
// Module  : four_bank_mem_if
// Brief   : Request/response bundle between the cache controller and the banked memory.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface four_bank_mem_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, rd_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, rd_valid, stall, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/four_bank_mem.sv
// ---------------------------------------------------------------------------
// Module  : four_bank_mem
// Brief   : Four word-interleaved memory banks with per-bank busy timers and a 2-cycle read pipe.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module four_bank_mem #(
    parameter int ROW_BITS  = 13,
    parameter int BANK_BUSY = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    four_bank_mem_if.slave   bus
);

    localparam int                 c_CNT_W    = (BANK_BUSY > 1) ? $clog2(BANK_BUSY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(BANK_BUSY - 1);
    localparam int                 c_DEPTH    = 1 << ROW_BITS;

    logic                 w_req;
    logic [1:0]           w_bank;
    logic [ROW_BITS-1:0]  w_row;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic [3:0]           w_busy;
    logic [3:0][15:0]     w_rd_word;

    logic                 r_v1;
    logic [15:0]          r_d1;
    logic                 r_v2;
    logic [15:0]          r_d2;

    assign w_req    = bus.rd | bus.wr;
    assign w_bank   = bus.addr[2:1];
    assign w_row    = bus.addr[3 +: ROW_BITS];
    assign w_err    = (bus.rd & bus.wr) | (w_req & bus.addr[0]);
    assign w_accept = w_req & ~w_err & ~w_busy[w_bank];
    assign w_rd_acc = w_accept & bus.rd;
    assign w_wr_acc = w_accept & bus.wr;

    assign bus.err      = w_err;
    assign bus.stall    = w_req & ~w_err & w_busy[w_bank];
    assign bus.busy     = w_busy;
    assign bus.rd_valid = r_v2;
    assign bus.data_out = r_d2;

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_bank
            logic [c_CNT_W-1:0] r_cnt;
            logic [15:0]        r_mem [c_DEPTH];

            // A bank counts down from BANK_BUSY-1 so it reads busy for the
            // BANK_BUSY-1 cycles following the accept cycle.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt <= '0;
                end else if (w_accept && (w_bank == 2'(b))) begin
                    r_cnt <= c_CNT_LOAD;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (w_wr_acc && (w_bank == 2'(b))) begin
                    r_mem[w_row] <= bus.data_in;
                end
            end

            assign w_busy[b]    = (r_cnt != '0);
            assign w_rd_word[b] = r_mem[w_row];
        end
    endgenerate

    // Idle pipe slots carry zero data so data_out is 0 whenever rd_valid is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1 <= 1'b0;
            r_d1 <= 16'h0000;
            r_v2 <= 1'b0;
            r_d2 <= 16'h0000;
        end else begin
            r_v1 <= w_rd_acc;
            r_d1 <= w_rd_acc ? w_rd_word[w_bank] : 16'h0000;
            r_v2 <= r_v1;
            r_d2 <= r_d1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_four_bank_mem.sv
// ---------------------------------------------------------------------------
// Module  : tb_four_bank_mem
// Brief   : Directed self-checking bench for the four-bank memory model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_four_bank_mem;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    four_bank_mem_if bus_if ();

    four_bank_mem #(
        .ROW_BITS (13),
        .BANK_BUSY(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: new inputs shortly after the rising edge, then settle to the falling edge.
    task automatic drive(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din);
        @(posedge clk);
        #1;
        bus_if.rd      = rd;
        bus_if.wr      = wr;
        bus_if.addr    = addr;
        bus_if.data_in = din;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic write_word(input logic [15:0] addr, input logic [15:0] din);
        int tries;
        tries = 0;
        drive(1'b0, 1'b1, addr, din);
        while (bus_if.stall === 1'b1 && tries < 10) begin
            tries++;
            drive(1'b0, 1'b1, addr, din);
        end
        if (tries >= 10) chk("write_timeout", 16'(bus_if.stall), 16'h0);
    endtask

    task automatic read_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        int tries;
        tries = 0;
        drive(1'b1, 1'b0, addr, 16'h0000);
        while (bus_if.stall === 1'b1 && tries < 10) begin
            tries++;
            drive(1'b1, 1'b0, addr, 16'h0000);
        end
        if (tries >= 10) chk({tag, "_timeout"}, 16'(bus_if.stall), 16'h0);
        idle(1);
        chk({tag, "_nv"}, 16'(bus_if.rd_valid), 16'h0);
        idle(1);
        chk({tag, "_v"}, 16'(bus_if.rd_valid), 16'h1);
        chk({tag, "_d"}, bus_if.data_out, exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        bus_if.rd = 1'b0; bus_if.wr = 1'b0;
        bus_if.addr = 16'h0000; bus_if.data_in = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 16'(bus_if.busy), 16'h0);
        chk("rst_valid", 16'(bus_if.rd_valid), 16'h0);
        chk("rst_dout", bus_if.data_out, 16'h0000);
        chk("rst_stall", 16'(bus_if.stall), 16'h0);
        chk("rst_err", 16'(bus_if.err), 16'h0);
        rst = 1'b1;

        // Preload one word per bank, plus a marker word for the error test.
        write_word(16'h0000, 16'hA0A0);
        write_word(16'h0002, 16'hA1A1);
        write_word(16'h0004, 16'hA2A2);
        write_word(16'h0006, 16'hA3A3);
        write_word(16'h0020, 16'h5555);
        idle(4);

        // 1: pipelined line fill across the four banks
        drive(1'b1, 1'b0, 16'h0000, 16'h0);
        chk("t1_stall0", 16'(bus_if.stall), 16'h0);
        drive(1'b1, 1'b0, 16'h0002, 16'h0);
        chk("t1_stall1", 16'(bus_if.stall), 16'h0);
        chk("t1_nv1", 16'(bus_if.rd_valid), 16'h0);
        drive(1'b1, 1'b0, 16'h0004, 16'h0);
        chk("t1_stall2", 16'(bus_if.stall), 16'h0);
        chk("t1_v2", 16'(bus_if.rd_valid), 16'h1);
        chk("t1_d2", bus_if.data_out, 16'hA0A0);
        drive(1'b1, 1'b0, 16'h0006, 16'h0);
        chk("t1_stall3", 16'(bus_if.stall), 16'h0);
        chk("t1_v3", 16'(bus_if.rd_valid), 16'h1);
        chk("t1_d3", bus_if.data_out, 16'hA1A1);
        idle(1);
        chk("t1_v4", 16'(bus_if.rd_valid), 16'h1);
        chk("t1_d4", bus_if.data_out, 16'hA2A2);
        idle(1);
        chk("t1_v5", 16'(bus_if.rd_valid), 16'h1);
        chk("t1_d5", bus_if.data_out, 16'hA3A3);
        idle(1);
        chk("t1_v6", 16'(bus_if.rd_valid), 16'h0);
        chk("t1_d6", bus_if.data_out, 16'h0000);
        idle(4);

        // 2: read stalls behind a write to the same bank, then sees the new data
        drive(1'b0, 1'b1, 16'h0010, 16'h1234);
        chk("t2_wstall", 16'(bus_if.stall), 16'h0);
        drive(1'b1, 1'b0, 16'h0010, 16'h0);
        chk("t2_stall1", 16'(bus_if.stall), 16'h1);
        drive(1'b1, 1'b0, 16'h0010, 16'h0);
        chk("t2_stall2", 16'(bus_if.stall), 16'h1);
        drive(1'b1, 1'b0, 16'h0010, 16'h0);
        chk("t2_stall3", 16'(bus_if.stall), 16'h1);
        drive(1'b1, 1'b0, 16'h0010, 16'h0);
        chk("t2_stall4", 16'(bus_if.stall), 16'h0);
        idle(1);
        chk("t2_nv5", 16'(bus_if.rd_valid), 16'h0);
        idle(1);
        chk("t2_v6", 16'(bus_if.rd_valid), 16'h1);
        chk("t2_d6", bus_if.data_out, 16'h1234);
        idle(4);

        // 3: illegal requests are dropped
        drive(1'b1, 1'b1, 16'h0020, 16'hDEAD);
        chk("t3_err_rw", 16'(bus_if.err), 16'h1);
        chk("t3_stall_rw", 16'(bus_if.stall), 16'h0);
        drive(1'b1, 1'b0, 16'h0021, 16'h0);
        chk("t3_err_odd", 16'(bus_if.err), 16'h1);
        chk("t3_stall_odd", 16'(bus_if.stall), 16'h0);
        chk("t3_busy1", 16'(bus_if.busy), 16'h0);
        idle(1);
        chk("t3_err_idle", 16'(bus_if.err), 16'h0);
        chk("t3_busy2", 16'(bus_if.busy), 16'h0);
        chk("t3_nv2", 16'(bus_if.rd_valid), 16'h0);
        idle(1);
        chk("t3_nv3", 16'(bus_if.rd_valid), 16'h0);
        read_check("t3_mem", 16'h0020, 16'h5555);
        idle(4);

        // 4: busy flags of two banks overlap
        drive(1'b0, 1'b1, 16'h0000, 16'hA0A0);
        chk("t4_busy0", 16'(bus_if.busy), 16'h0);
        drive(1'b0, 1'b1, 16'h0002, 16'hA1A1);
        chk("t4_busy1", 16'(bus_if.busy), 16'h1);
        idle(1);
        chk("t4_busy2", 16'(bus_if.busy), 16'h3);
        idle(1);
        chk("t4_busy3", 16'(bus_if.busy), 16'h3);
        idle(1);
        chk("t4_busy4", 16'(bus_if.busy), 16'h2);
        idle(1);
        chk("t4_busy5", 16'(bus_if.busy), 16'h0);
        idle(2);

        // 5: reset discards an in-flight read
        drive(1'b1, 1'b0, 16'h0004, 16'h0);
        chk("t5_acc", 16'(bus_if.stall), 16'h0);
        drive(1'b0, 1'b0, 16'h0000, 16'h0);
        rst = 1'b0;
        #1;
        chk("t5_rst_v", 16'(bus_if.rd_valid), 16'h0);
        chk("t5_rst_d", bus_if.data_out, 16'h0000);
        chk("t5_rst_busy", 16'(bus_if.busy), 16'h0);
        idle(1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("t5_post_nv", 16'(bus_if.rd_valid), 16'h0);
        end
        read_check("t5_mem2", 16'h0004, 16'hA2A2);
        read_check("t5_mem1", 16'h0002, 16'hA1A1);
        idle(4);

        // 6: top row of bank 3 does not alias row 0
        write_word(16'hFFFE, 16'hBEEF);
        read_check("t6_top", 16'hFFFE, 16'hBEEF);
        read_check("t6_row0", 16'h0006, 16'hA3A3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
